// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: value-side and pin-side signals of the seven-segment scan driver
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int SEL_W = $clog2(NUM_DIGITS);

    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic [SEL_W-1:0]        digit_sel;
    logic                    frame_done;

    modport master (
        output enable, load, digits_in, dp_in, blank_lz,
        input  an, seg, dp, digit_sel, frame_done
    );

    modport slave (
        input  enable, load, digits_in, dp_in, blank_lz,
        output an, seg, dp, digit_sel, frame_done
    );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed seven-segment driver with hex decode, zero blanking and double-buffered digits
module seg_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter bit AN_ACTIVE_LOW = 1
) (
    input logic           clk,
    input logic           reset,
    seg_scan_mux_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]        cnt;
    logic [SEL_W-1:0]        sel;
    logic                    frame_done;
    logic [4*NUM_DIGITS-1:0] pending, active;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic                    pending_valid;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    tc, last, wrap;
    logic [NUM_DIGITS-1:0]   lz, onehot, an_nxt;
    logic [3:0]              cur;
    logic                    blank;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign tc   = cnt == CNT_W'(REFRESH_DIV - 1);
    assign last = sel == SEL_W'(NUM_DIGITS - 1);
    assign wrap = bus.enable && tc && last;

    // Refresh counter and digit scan; frame_done marks the cycle digit_sel returns to 0
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            sel        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (bus.enable) begin
                cnt <= tc ? '0 : cnt + CNT_W'(1);
                if (tc) sel <= last ? '0 : sel + SEL_W'(1);
            end
        end
    end

    // Pending/active buffers; a load coinciding with a wrap bypasses pending straight to active
    always_ff @(posedge clk) begin
        if (reset) begin
            pending       <= '0;
            pend_dp       <= '0;
            active        <= '0;
            act_dp        <= '0;
            pending_valid <= 1'b0;
        end else begin
            if (bus.load) begin
                pending <= bus.digits_in;
                pend_dp <= bus.dp_in;
            end
            if (wrap && (bus.load || pending_valid)) begin
                active <= bus.load ? bus.digits_in : pending;
                act_dp <= bus.load ? bus.dp_in : pend_dp;
            end
            pending_valid <= wrap ? 1'b0 : (bus.load || pending_valid);
        end
    end

    // Leading-zero chain, selected digit decode and anode pattern for the current scan position
    always_comb begin
        lz = '0;
        lz[NUM_DIGITS-1] = active[4*NUM_DIGITS-1 -: 4] == 4'd0;
        for (int i = NUM_DIGITS - 2; i >= 0; i--) lz[i] = lz[i+1] && (active[4*i +: 4] == 4'd0);
        cur     = active[4*int'(sel) +: 4];
        blank   = bus.blank_lz && (sel != '0) && lz[sel];
        seg_nxt = blank ? 7'b1111111 : hex7(cur);
        dp_nxt  = ~act_dp[sel];
        onehot  = NUM_DIGITS'(1) << sel;
        an_nxt  = AN_ACTIVE_LOW ? ~onehot : onehot;
    end

    // Registered pin drivers; display goes dark while disabled
    always_ff @(posedge clk) begin
        if (reset || !bus.enable) begin
            an_q  <= AN_OFF;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.digit_sel  = sel;
    assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed scoreboard bench for the 4-digit scan driver with a 4-cycle refresh
module tb_seg_scan_mux;
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] sel;
        logic       fd;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;
    obs_t sb[$];
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_mux_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .AN_ACTIVE_LOW(1)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Expected pins at step j (1..16) after a frame start: digit k lit for 4 samples, digit_sel one ahead
    function automatic obs_t entry(int j, logic [15:0] d, logic [3:0] dv, logic blz);
        obs_t e;
        int k;
        logic [15:0] sh;
        k = (j - 1) / 4;
        sh = d >> (4 * k);
        e.an = ~(4'b0001 << k);
        e.seg = (blz && k != 0 && sh == 16'd0) ? 7'h7F : tbl[sh[3:0]];
        e.dp = ~dv[k];
        e.sel = 2'((j / 4) % 4);
        e.fd = (j == 16);
        return e;
    endfunction

    function automatic obs_t off(logic [1:0] s);
        obs_t e;
        e.an = 4'hF;
        e.seg = 7'h7F;
        e.dp = 1'b1;
        e.sel = s;
        e.fd = 1'b0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag);
        obs_t got, want;
        got = {bus.an, bus.seg, bus.dp, bus.digit_sel, bus.frame_done};
        want = sb.pop_front();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got an=%b seg=%b dp=%b sel=%0d fd=%b want an=%b seg=%b dp=%b sel=%0d fd=%b",
                   tag, got.an, got.seg, got.dp, got.sel, got.fd,
                   want.an, want.seg, want.dp, want.sel, want.fd);
        end
    endtask

    // Run steps 1..stop of a frame showing d/dv, optionally pulsing load at steps la and lb
    task automatic run_frame(string tag, logic [15:0] d, logic [3:0] dv,
                             int la, logic [15:0] da, int lb, logic [15:0] db, int stop);
        for (int j = 1; j <= stop; j++) begin
            bus.load = (j == la) || (j == lb);
            bus.digits_in = (j == lb) ? db : da;
            sb.push_back(entry(j, d, dv, bus.blank_lz));
            tick();
            bus.load = 1'b0;
            chk($sformatf("%s[%0d]", tag, j));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.load = 1'b0;
        bus.digits_in = '0;
        bus.dp_in = '0;
        bus.blank_lz = 1'b0;
        tick();
        tick();
        sb.push_back(off(2'd0));
        chk("reset");
        reset = 1'b0;
        bus.enable = 1'b1;
        run_frame("boot", 16'h0000, 4'b0000, 1, 16'h1234, 0, 16'h0, 16);
        run_frame("f1234", 16'h1234, 4'b0000, 0, 16'h0, 0, 16'h0, 16);
        bus.dp_in = 4'b0100;
        bus.blank_lz = 1'b1;
        run_frame("f1234_ld7", 16'h1234, 4'b0000, 3, 16'h0007, 0, 16'h0, 16);
        run_frame("lz_on", 16'h0007, 4'b0100, 0, 16'h0, 0, 16'h0, 16);
        bus.blank_lz = 1'b0;
        bus.dp_in = 4'b0000;
        run_frame("lz_off", 16'h0007, 4'b0100, 2, 16'h1111, 0, 16'h0, 16);
        run_frame("f1111", 16'h1111, 4'b0000, 6, 16'hAAAA, 10, 16'hBEEF, 16);
        run_frame("fbeef", 16'hBEEF, 4'b0000, 5, 16'h9999, 16, 16'h5555, 16);
        run_frame("f5555", 16'h5555, 4'b0000, 0, 16'h0, 0, 16'h0, 16);
        run_frame("f5555b", 16'h5555, 4'b0000, 0, 16'h0, 0, 16'h0, 16);
        for (int j = 1; j <= 2; j++) begin
            sb.push_back(entry(j, 16'h5555, 4'b0000, 1'b0));
            tick();
            chk($sformatf("en_pre[%0d]", j));
        end
        bus.enable = 1'b0;
        for (int n = 0; n < 10; n++) begin
            bus.load = (n == 3);
            bus.digits_in = 16'h2222;
            sb.push_back(off(2'd0));
            tick();
            bus.load = 1'b0;
            chk($sformatf("en_off[%0d]", n));
        end
        bus.enable = 1'b1;
        for (int j = 3; j <= 16; j++) begin
            sb.push_back(entry(j, 16'h5555, 4'b0000, 1'b0));
            tick();
            chk($sformatf("en_resume[%0d]", j));
        end
        run_frame("f2222", 16'h2222, 4'b0000, 3, 16'h8888, 0, 16'h0, 8);
        reset = 1'b1;
        sb.push_back(off(2'd0));
        tick();
        chk("reset_mid");
        reset = 1'b0;
        bus.blank_lz = 1'b1;
        run_frame("post_rst", 16'h0000, 4'b0000, 0, 16'h0, 0, 16'h0, 16);
        run_frame("post_rst2", 16'h0000, 4'b0000, 0, 16'h0, 0, 16'h0, 16);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
